// File: rtl/pong_input_pkg.sv
// Shared command encodings and source states for the Pong player-input hub.
// A received byte is split as [7:4] opcode, [3:2] player, [1:0] argument.
package pong_input_pkg;

    localparam logic [3:0] OP_PADDLE  = 4'h1;
    localparam logic [3:0] OP_START   = 4'h2;
    localparam logic [3:0] OP_PAUSE   = 4'h3;
    localparam logic [3:0] OP_RELEASE = 4'h4;

    localparam logic [1:0] ARG_UP = 2'b01;
    localparam logic [1:0] ARG_DN = 2'b10;

    typedef enum logic {
        SRC_BTN  = 1'b0,
        SRC_UART = 1'b1
    } src_e;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] player;
        logic [1:0] arg;
    } cmd_t;

    function automatic cmd_t decode_byte(input logic [7:0] b);
        return cmd_t'(b);
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Single-channel switch debouncer: the stable state follows the raw input only
// after the raw input has differed from it for DEBOUNCE_LIMIT consecutive clocks.
module input_debounce #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Stable
);

    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;

    logic [CNT_W-1:0] r_cnt_r;

    // The clock that would bring the count to the limit commits the raw value instead.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cnt_r  <= '0;
            o_Stable <= 1'b0;
        end else if (i_Raw == o_Stable) begin
            r_cnt_r  <= '0;
        end else if (r_cnt_r == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
            r_cnt_r  <= '0;
            o_Stable <= i_Raw;
        end else begin
            r_cnt_r  <= r_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pong_input_hub.sv
// Player-input front end for Pong: debounced buttons or UART command bytes drive
// each paddle, with per-player source arbitration, pause and game-start control.
module pong_input_hub
    import pong_input_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int UART_HOLD      = 2500000
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic [2*NUM_PLAYERS-1:0] i_Switch,
    input  logic                     i_RX_DV,
    input  logic [7:0]               i_RX_Byte,
    output logic [NUM_PLAYERS-1:0]   o_Paddle_Up,
    output logic [NUM_PLAYERS-1:0]   o_Paddle_Dn,
    output logic                     o_Game_Start,
    output logic                     o_Pause,
    output logic [NUM_PLAYERS-1:0]   o_Src_UART
);

    localparam int HOLD_W = $clog2(UART_HOLD + 1);

    cmd_t                     w_cmd_s;
    logic [2*NUM_PLAYERS-1:0] w_deb_s;
    logic [2*NUM_PLAYERS-1:0] r_deb_prev_r;
    logic [NUM_PLAYERS-1:0]   w_pad_cmd_s;
    logic [NUM_PLAYERS-1:0]   w_rel_cmd_s;
    logic [NUM_PLAYERS-1:0]   w_rise_s;

    src_e r_src_r     [NUM_PLAYERS];
    src_e w_src_nxt_s [NUM_PLAYERS];

    logic [HOLD_W-1:0]      r_hold_r     [NUM_PLAYERS];
    logic [HOLD_W-1:0]      w_hold_nxt_s [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] r_up_dir_r, w_up_dir_nxt_s;
    logic [NUM_PLAYERS-1:0] r_dn_dir_r, w_dn_dir_nxt_s;
    logic [NUM_PLAYERS-1:0] w_req_up_s, w_req_dn_s;
    logic [NUM_PLAYERS-1:0] w_up_nxt_s, w_dn_nxt_s;
    logic                   r_pause_r, w_pause_nxt_s, w_start_nxt_s;

    assign w_cmd_s = decode_byte(i_RX_Byte);
    assign o_Pause = r_pause_r;

    for (genvar i = 0; i < 2 * NUM_PLAYERS; i++) begin : g_deb
        input_debounce #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
        ) u_deb (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Raw    (i_Switch[i]),
            .o_Stable (w_deb_s[i])
        );
    end

    // Per-player command strobes and source next-state; a paddle command beats a local override.
    always_comb begin
        w_pad_cmd_s = '0;
        w_rel_cmd_s = '0;
        w_rise_s    = '0;
        o_Src_UART  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_src_nxt_s[p] = r_src_r[p];
            o_Src_UART[p]  = (r_src_r[p] == SRC_UART);
            w_rise_s[p]    = |(w_deb_s[2*p +: 2] & ~r_deb_prev_r[2*p +: 2]);
            if (i_RX_DV && (w_cmd_s.player == 2'(p))) begin
                w_pad_cmd_s[p] = (w_cmd_s.op == OP_PADDLE);
                w_rel_cmd_s[p] = (w_cmd_s.op == OP_RELEASE);
            end else begin
                w_pad_cmd_s[p] = 1'b0;
                w_rel_cmd_s[p] = 1'b0;
            end
            case (r_src_r[p])
                SRC_BTN: begin
                    if (w_pad_cmd_s[p]) w_src_nxt_s[p] = SRC_UART;
                    else                w_src_nxt_s[p] = SRC_BTN;
                end
                SRC_UART: begin
                    if (w_pad_cmd_s[p])                     w_src_nxt_s[p] = SRC_UART;
                    else if (w_rel_cmd_s[p] || w_rise_s[p]) w_src_nxt_s[p] = SRC_BTN;
                    else                                    w_src_nxt_s[p] = SRC_UART;
                end
                default: w_src_nxt_s[p] = SRC_BTN;
            endcase
        end
    end

    // Pause/start decode, UART hold timers and the next paddle outputs.
    always_comb begin
        w_hold_nxt_s   = r_hold_r;
        w_up_dir_nxt_s = r_up_dir_r;
        w_dn_dir_nxt_s = r_dn_dir_r;
        w_req_up_s     = '0;
        w_req_dn_s     = '0;
        w_up_nxt_s     = '0;
        w_dn_nxt_s     = '0;
        w_start_nxt_s  = 1'b0;
        w_pause_nxt_s  = r_pause_r;
        if (i_RX_DV && (w_cmd_s.op == OP_START)) begin
            w_start_nxt_s = 1'b1;
            w_pause_nxt_s = 1'b0;
        end else if (i_RX_DV && (w_cmd_s.op == OP_PAUSE)) begin
            w_pause_nxt_s = ~r_pause_r;
        end else begin
            w_pause_nxt_s = r_pause_r;
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_pad_cmd_s[p]) begin
                case (w_cmd_s.arg)
                    ARG_UP: begin
                        w_up_dir_nxt_s[p] = 1'b1;
                        w_dn_dir_nxt_s[p] = 1'b0;
                        w_hold_nxt_s[p]   = HOLD_W'(UART_HOLD);
                    end
                    ARG_DN: begin
                        w_up_dir_nxt_s[p] = 1'b0;
                        w_dn_dir_nxt_s[p] = 1'b1;
                        w_hold_nxt_s[p]   = HOLD_W'(UART_HOLD);
                    end
                    default: begin
                        w_up_dir_nxt_s[p] = 1'b0;
                        w_dn_dir_nxt_s[p] = 1'b0;
                        w_hold_nxt_s[p]   = '0;
                    end
                endcase
            end else if (w_rel_cmd_s[p]) begin
                w_up_dir_nxt_s[p] = 1'b0;
                w_dn_dir_nxt_s[p] = 1'b0;
                w_hold_nxt_s[p]   = '0;
            end else if (r_hold_r[p] != '0) begin
                w_hold_nxt_s[p] = r_hold_r[p] - HOLD_W'(1);
            end else begin
                w_up_dir_nxt_s[p] = 1'b0;
                w_dn_dir_nxt_s[p] = 1'b0;
            end
            w_req_up_s[p] = (r_src_r[p] == SRC_UART) ? r_up_dir_r[p] : w_deb_s[2*p];
            w_req_dn_s[p] = (r_src_r[p] == SRC_UART) ? r_dn_dir_r[p] : w_deb_s[2*p+1];
            w_up_nxt_s[p] = w_req_up_s[p] & ~w_req_dn_s[p] & ~r_pause_r;
            w_dn_nxt_s[p] = w_req_dn_s[p] & ~w_req_up_s[p] & ~r_pause_r;
        end
    end

    // Source state register per player.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int p = 0; p < NUM_PLAYERS; p++) r_src_r[p] <= SRC_BTN;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) r_src_r[p] <= w_src_nxt_s[p];
        end
    end

    // Datapath state and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int p = 0; p < NUM_PLAYERS; p++) r_hold_r[p] <= '0;
            r_up_dir_r   <= '0;
            r_dn_dir_r   <= '0;
            r_deb_prev_r <= '0;
            r_pause_r    <= 1'b0;
            o_Game_Start <= 1'b0;
            o_Paddle_Up  <= '0;
            o_Paddle_Dn  <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) r_hold_r[p] <= w_hold_nxt_s[p];
            r_up_dir_r   <= w_up_dir_nxt_s;
            r_dn_dir_r   <= w_dn_dir_nxt_s;
            r_deb_prev_r <= w_deb_s;
            r_pause_r    <= w_pause_nxt_s;
            o_Game_Start <= w_start_nxt_s;
            o_Paddle_Up  <= w_up_nxt_s;
            o_Paddle_Dn  <= w_dn_nxt_s;
        end
    end

endmodule
